// File: rtl/mem_pkg.sv
// Shared types and defaults for the mem register file read port.
package mem_pkg;

    localparam int REG_SIZE = 32;
    localparam int MEM_SIZE = 32;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ADDR_W = addr_width(MEM_SIZE);

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [REG_SIZE-1:0] data_t;

    typedef struct packed {
        data_t data;
        addr_t addr;
        logic  err;
    } rd_rsp_t;

endpackage

// File: rtl/mem_rd_fifo.sv
// Generic address queue with push/pop, full/empty flags and an occupancy count.
module mem_rd_fifo
    import mem_pkg::*;
#(
    parameter int W     = ADDR_W,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  entries_q [DEPTH];
    logic [W-1:0]  entries_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = entries_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        do_push   = push && !full;
        do_pop    = pop && !empty;
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push) begin
            entries_d[wr_ptr_q] = push_data;
            wr_ptr_d            = wrap_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = wrap_inc(rd_ptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

endmodule

// File: rtl/mem_rd_port.sv
// Queued read port for the mem register file with a registered response.
// MEM_RD_BYPASS_EN adds wr_en/wr_addr/wr_data write-then-read forwarding.
module mem_rd_port
    import mem_pkg::*;
#(
    parameter int reg_size   = REG_SIZE,
    parameter int mem_size   = MEM_SIZE,
    parameter int FIFO_DEPTH = 2,
    parameter int AW         = addr_width(mem_size),
    parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [mem_size-1:0][reg_size-1:0]  mem_dout,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [AW-1:0]                      req_addr,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [reg_size-1:0]                rsp_data,
    output logic [AW-1:0]                      rsp_addr,
    output logic                               rsp_err,
`ifdef MEM_RD_BYPASS_EN
    input  logic                               wr_en,
    input  logic [AW-1:0]                      wr_addr,
    input  logic [reg_size-1:0]                wr_data,
`endif
    output logic [CW-1:0]                      q_count
);

    typedef struct packed {
        logic [reg_size-1:0] data;
        logic [AW-1:0]       addr;
        logic                err;
    } rsp_t;

    rsp_t                rsp_q, rsp_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [AW-1:0]       head;
    logic                full, empty;
    logic                load, drain, hold;
    logic                head_err;
    logic [reg_size-1:0] head_word;

    mem_rd_fifo #(
        .W     (AW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid),
        .push_data (req_addr),
        .pop       (load),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (q_count)
    );

    assign req_ready = !full;
    assign load      = !empty && (!rsp_valid_q || rsp_ready);
    assign drain     = empty && rsp_valid_q && rsp_ready;
    assign hold      = rsp_valid_q && !rsp_ready;
    assign head_err  = (32'(head) >= 32'(mem_size));
    assign head_word = head_err ? '0 : mem_dout[head];

    always_comb begin
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        unique case (1'b1)
            load: begin
                rsp_valid_d = 1'b1;
                rsp_d.addr  = head;
                rsp_d.err   = head_err;
                rsp_d.data  = head_word;
`ifdef MEM_RD_BYPASS_EN
                if (wr_en && wr_addr == head && !head_err)
                    rsp_d.data = wr_data;
`endif
            end
            drain: rsp_valid_d = 1'b0;
            hold: begin
`ifdef MEM_RD_BYPASS_EN
                // Keep the held word coherent with a write landing in mem now.
                if (wr_en && wr_addr == rsp_q.addr && !rsp_q.err)
                    rsp_d.data = wr_data;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_q.data;
    assign rsp_addr  = rsp_q.addr;
    assign rsp_err   = rsp_q.err;

endmodule
